// File: rtl/ycbcr444_to_rgb888.sv
`default_nettype none
// ============================================================================
// Module      : ycbcr444_to_rgb888
// Description : Full-range BT.601 YCbCr444 to RGB888. Four-stage data
//               pipeline, matching sync delay line and input format checker.
// Revision    : 1.0 - initial release
// ============================================================================
module ycbcr444_to_rgb888 #(
    parameter int MD_SIM_ABLE = 0,
    parameter int WD_IMG_DATA = 8,
    parameter int WD_ERR_INFO = 4,
    parameter int NB_IMG_W    = 960,
    parameter int NB_IMG_H    = 640
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_resetn,
    input  logic                   s_img_ycbcr444_c_fsync,
    input  logic                   s_img_ycbcr444_c_vsync,
    input  logic                   s_img_ycbcr444_c_hsync,
    input  logic [WD_IMG_DATA-1:0] s_img_ycbcr444_y_mdat0,
    input  logic [WD_IMG_DATA-1:0] s_img_ycbcr444_b_mdat1,
    input  logic [WD_IMG_DATA-1:0] s_img_ycbcr444_r_mdat2,
    output logic                   m_img_rgb888_c_fsync,
    output logic                   m_img_rgb888_c_vsync,
    output logic                   m_img_rgb888_c_hsync,
    output logic [WD_IMG_DATA-1:0] m_img_rgb888_r_mdat0,
    output logic [WD_IMG_DATA-1:0] m_img_rgb888_g_mdat1,
    output logic [WD_IMG_DATA-1:0] m_img_rgb888_b_mdat2,
    output logic [WD_ERR_INFO-1:0] m_err_ycbcr444_info1
);

    localparam int W_C   = WD_IMG_DATA + 1;
    localparam int W_P   = WD_IMG_DATA + 12;
    localparam int W_S   = WD_IMG_DATA + 14;
    localparam int W_PIX = $clog2(NB_IMG_W + 2);
    localparam int W_LIN = $clog2(NB_IMG_H + 2);

    localparam logic        [W_C-1:0] c_ofs   = W_C'(1 << (WD_IMG_DATA - 1));
    localparam logic signed [W_P-1:0] c_k_rv  = W_P'(1436);
    localparam logic signed [W_P-1:0] c_k_gu  = W_P'(352);
    localparam logic signed [W_P-1:0] c_k_gv  = W_P'(731);
    localparam logic signed [W_P-1:0] c_k_bu  = W_P'(1815);
    localparam logic signed [W_S-1:0] c_rnd   = W_S'(512);
    localparam logic signed [W_S-1:0] c_max   = W_S'((1 << WD_IMG_DATA) - 1);

    logic        [WD_IMG_DATA-1:0] r_y1, r_y2;
    logic signed [W_C-1:0]         r_cb, r_cr;
    logic signed [W_P-1:0]         r_p_rv, r_p_gu, r_p_gv, r_p_bu;
    logic signed [W_S-1:0]         r_s_r, r_s_g, r_s_b;
    logic        [WD_IMG_DATA-1:0] r_r, r_g, r_b;
    logic        [2:0]             r_sync [4];

    logic signed [W_S-1:0] w_y_sh;
    assign w_y_sh = {4'b0000, r_y2, 10'd0};

    // Floor shift then clamp into the unsigned component range
    function automatic logic [WD_IMG_DATA-1:0] f_sat(input logic signed [W_S-1:0] v);
        if (v < 0)
            f_sat = '0;
        else if (v > c_max)
            f_sat = '1;
        else
            f_sat = v[WD_IMG_DATA-1:0];
    endfunction

    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            r_y1   <= '0;
            r_y2   <= '0;
            r_cb   <= '0;
            r_cr   <= '0;
            r_p_rv <= '0;
            r_p_gu <= '0;
            r_p_gv <= '0;
            r_p_bu <= '0;
            r_s_r  <= '0;
            r_s_g  <= '0;
            r_s_b  <= '0;
            r_r    <= '0;
            r_g    <= '0;
            r_b    <= '0;
            for (int i = 0; i < 4; i++) r_sync[i] <= '0;
        end else begin
            r_y1   <= s_img_ycbcr444_y_mdat0;
            r_cb   <= {1'b0, s_img_ycbcr444_b_mdat1} - c_ofs;
            r_cr   <= {1'b0, s_img_ycbcr444_r_mdat2} - c_ofs;
            r_y2   <= r_y1;
            r_p_rv <= W_P'(r_cr) * c_k_rv;
            r_p_gu <= W_P'(r_cb) * c_k_gu;
            r_p_gv <= W_P'(r_cr) * c_k_gv;
            r_p_bu <= W_P'(r_cb) * c_k_bu;
            r_s_r  <= w_y_sh + W_S'(r_p_rv) + c_rnd;
            r_s_g  <= w_y_sh - W_S'(r_p_gu) - W_S'(r_p_gv) + c_rnd;
            r_s_b  <= w_y_sh + W_S'(r_p_bu) + c_rnd;
            r_r    <= f_sat(r_s_r >>> 10);
            r_g    <= f_sat(r_s_g >>> 10);
            r_b    <= f_sat(r_s_b >>> 10);
            r_sync[0] <= {s_img_ycbcr444_c_fsync, s_img_ycbcr444_c_vsync, s_img_ycbcr444_c_hsync};
            for (int i = 1; i < 4; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign m_img_rgb888_r_mdat0 = r_r;
    assign m_img_rgb888_g_mdat1 = r_g;
    assign m_img_rgb888_b_mdat2 = r_b;
    assign {m_img_rgb888_c_fsync, m_img_rgb888_c_vsync, m_img_rgb888_c_hsync} = r_sync[3];

    logic             r_fs_d, r_vs_d;
    logic [W_PIX-1:0] r_pix;
    logic [W_LIN-1:0] r_line;
    logic [3:0]       r_err;
    logic             w_fs_rise, w_fs_fall, w_vs_rise, w_vs_fall;
    logic [W_LIN-1:0] w_line_nxt;
    logic [3:0]       w_set;

    assign w_fs_rise = s_img_ycbcr444_c_fsync & ~r_fs_d;
    assign w_fs_fall = ~s_img_ycbcr444_c_fsync & r_fs_d;
    assign w_vs_rise = s_img_ycbcr444_c_vsync & ~r_vs_d;
    assign w_vs_fall = ~s_img_ycbcr444_c_vsync & r_vs_d;

    // Includes a line that ends on the same cycle the frame ends
    assign w_line_nxt = (w_vs_fall && (r_line != '1)) ? r_line + 1'b1 : r_line;

    assign w_set[0] = s_img_ycbcr444_c_hsync & ~s_img_ycbcr444_c_vsync;
    assign w_set[1] = w_vs_fall & (r_pix != W_PIX'(NB_IMG_W));
    assign w_set[2] = w_fs_fall & (w_line_nxt != W_LIN'(NB_IMG_H));
    assign w_set[3] = s_img_ycbcr444_c_vsync & ~s_img_ycbcr444_c_fsync;

    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            r_fs_d <= 1'b0;
            r_vs_d <= 1'b0;
            r_pix  <= '0;
            r_line <= '0;
            r_err  <= '0;
        end else begin
            r_fs_d <= s_img_ycbcr444_c_fsync;
            r_vs_d <= s_img_ycbcr444_c_vsync;
            if (w_vs_rise)
                r_pix <= W_PIX'(s_img_ycbcr444_c_hsync);
            else if (s_img_ycbcr444_c_vsync && s_img_ycbcr444_c_hsync && (r_pix != '1))
                r_pix <= r_pix + 1'b1;
            if (w_fs_rise)
                r_line <= W_LIN'(w_vs_fall);
            else
                r_line <= w_line_nxt;
            r_err <= (w_fs_rise ? 4'b0000 : r_err) | w_set;
        end
    end

    generate
        if (WD_ERR_INFO > 4) begin : g_err_pad
            assign m_err_ycbcr444_info1 = {{(WD_ERR_INFO-4){1'b0}}, r_err};
        end else begin : g_err_nopad
            assign m_err_ycbcr444_info1 = r_err[WD_ERR_INFO-1:0];
        end
        // Error-message hook is simulation-only; hardware is identical either way
        if (MD_SIM_ABLE != 0) begin : g_sim_mon
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ycbcr444_to_rgb888.sv
`default_nettype none
// ============================================================================
// Module      : tb_ycbcr444_to_rgb888
// Description : Randomized bench for ycbcr444_to_rgb888 with reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ycbcr444_to_rgb888;

    localparam int W = 8;
    localparam int H = 3;

    typedef struct {
        logic [7:0] r, g, b;
        logic [2:0] s;
    } exp_t;

    logic       i_sys_clk = 1'b0;
    logic       i_sys_resetn = 1'b0;
    logic       fs = 1'b0, vs = 1'b0, hs = 1'b0;
    logic [7:0] yi = '0, cbi = '0, cri = '0;
    logic       o_fs, o_vs, o_hs;
    logic [7:0] o_r, o_g, o_b;
    logic [3:0] o_err;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];

    always #5 i_sys_clk = ~i_sys_clk;

    ycbcr444_to_rgb888 #(
        .MD_SIM_ABLE(0), .WD_IMG_DATA(8), .WD_ERR_INFO(4), .NB_IMG_W(W), .NB_IMG_H(H)
    ) dut (
        .i_sys_clk              (i_sys_clk),
        .i_sys_resetn           (i_sys_resetn),
        .s_img_ycbcr444_c_fsync (fs),
        .s_img_ycbcr444_c_vsync (vs),
        .s_img_ycbcr444_c_hsync (hs),
        .s_img_ycbcr444_y_mdat0 (yi),
        .s_img_ycbcr444_b_mdat1 (cbi),
        .s_img_ycbcr444_r_mdat2 (cri),
        .m_img_rgb888_c_fsync   (o_fs),
        .m_img_rgb888_c_vsync   (o_vs),
        .m_img_rgb888_c_hsync   (o_hs),
        .m_img_rgb888_r_mdat0   (o_r),
        .m_img_rgb888_g_mdat1   (o_g),
        .m_img_rgb888_b_mdat2   (o_b),
        .m_err_ycbcr444_info1   (o_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] clamp(input int v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    // Reference: JFIF inverse with Q10 coefficients, round then floor
    function automatic exp_t model(input logic f, v, h, input logic [7:0] y, cb, cr);
        exp_t e;
        int   yy = int'(y);
        int   u  = int'(cb) - 128;
        int   w  = int'(cr) - 128;
        e.r = clamp((yy * 1024 + 1436 * w + 512) >>> 10);
        e.g = clamp((yy * 1024 - 352 * u - 731 * w + 512) >>> 10);
        e.b = clamp((yy * 1024 + 1815 * u + 512) >>> 10);
        e.s = {f, v, h};
        return e;
    endfunction

    function automatic exp_t zero_e();
        exp_t e;
        e.r = '0; e.g = '0; e.b = '0; e.s = '0;
        return e;
    endfunction

    task automatic cyc(input logic f, v, h, input logic [7:0] y, cb, cr);
        exp_t e;
        @(negedge i_sys_clk);
        e = q.pop_front();
        check_eq("r",    32'(o_r), 32'(e.r));
        check_eq("g",    32'(o_g), 32'(e.g));
        check_eq("b",    32'(o_b), 32'(e.b));
        check_eq("sync", 32'({o_fs, o_vs, o_hs}), 32'(e.s));
        q.push_back(model(f, v, h, y, cb, cr));
        fs = f; vs = v; hs = h; yi = y; cbi = cb; cri = cr;
    endtask

    task automatic rcyc(input logic f, v, h);
        cyc(f, v, h, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic release_reset();
        @(negedge i_sys_clk);
        fs = 0; vs = 0; hs = 0; yi = 0; cbi = 0; cri = 0;
        i_sys_resetn = 1'b1;
        q.delete();
        repeat (3) q.push_back(zero_e());
        q.push_back(model(0, 0, 0, 8'd0, 8'd0, 8'd0));
    endtask

    task automatic line(input int npix, input logic f);
        rcyc(f, 1, 0);
        for (int i = 0; i < npix; i++) begin
            if ($urandom_range(3) == 0) rcyc(f, 1, 0);
            rcyc(f, 1, 1);
        end
        rcyc(f, 0, 0);
        rcyc(f, 0, 0);
    endtask

    task automatic frame(input int nl, input int bad_line, input int bad_pix);
        rcyc(1, 0, 0);
        for (int l = 0; l < nl; l++) line((l == bad_line) ? bad_pix : W, 1'b1);
        rcyc(0, 0, 0);
        rcyc(0, 0, 0);
    endtask

    initial begin
        repeat (2) @(negedge i_sys_clk);
        check_eq("rst_r",    32'(o_r), 32'd0);
        check_eq("rst_g",    32'(o_g), 32'd0);
        check_eq("rst_b",    32'(o_b), 32'd0);
        check_eq("rst_sync", 32'({o_fs, o_vs, o_hs}), 32'd0);
        check_eq("rst_err",  32'(o_err), 32'd0);
        release_reset();
        repeat (3) rcyc(0, 0, 0);
        check_eq("err_idle", 32'(o_err), 32'd0);

        // Directed corner pixels inside a short one-line frame
        cyc(1, 0, 0, 8'd0,   8'd0,   8'd0);
        cyc(1, 1, 1, 8'd128, 8'd128, 8'd128);
        cyc(1, 1, 1, 8'd255, 8'd128, 8'd255);
        cyc(1, 1, 1, 8'd0,   8'd0,   8'd128);
        cyc(1, 1, 1, 8'd76,  8'd85,  8'd255);
        cyc(1, 0, 0, 8'd0,   8'd0,   8'd0);
        repeat (2) rcyc(0, 0, 0);
        check_eq("err_short_frame", 32'(o_err), 32'h6);

        frame(H, -1, 0);
        check_eq("err_good_frame", 32'(o_err), 32'h0);
        frame(H, 1, W - 1);
        check_eq("err_short_line", 32'(o_err), 32'h2);
        frame(H - 1, -1, 0);
        check_eq("err_few_lines", 32'(o_err), 32'h4);
        frame(H, 0, W + 1);
        check_eq("err_long_line", 32'(o_err), 32'h2);

        rcyc(1, 0, 0);
        rcyc(1, 0, 0);
        check_eq("err_clear_fs", 32'(o_err), 32'h0);
        rcyc(1, 0, 1);
        for (int l = 0; l < H; l++) line(W, 1'b1);
        rcyc(0, 0, 0);
        rcyc(0, 0, 0);
        check_eq("err_h_no_v", 32'(o_err), 32'h1);

        frame(H, -1, 0);
        check_eq("err_good_frame2", 32'(o_err), 32'h0);
        line(W, 1'b0);
        check_eq("err_v_no_f", 32'(o_err), 32'h8);

        // Asynchronous reset in the middle of a line
        rcyc(1, 0, 0);
        repeat (3) rcyc(1, 1, 1);
        #2 i_sys_resetn = 1'b0;
        #1;
        check_eq("mid_rst_r",    32'(o_r), 32'd0);
        check_eq("mid_rst_g",    32'(o_g), 32'd0);
        check_eq("mid_rst_b",    32'(o_b), 32'd0);
        check_eq("mid_rst_sync", 32'({o_fs, o_vs, o_hs}), 32'd0);
        check_eq("mid_rst_err",  32'(o_err), 32'd0);
        release_reset();

        frame(H, -1, 0);
        check_eq("err_after_rst", 32'(o_err), 32'h0);
        repeat (200) rcyc(1'($urandom), 1'($urandom), 1'($urandom));
        repeat (5) rcyc(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
